// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and mux-select constants for the GCD datapath and controller
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] A_SEL_IN  = 2'd0;
    localparam logic [1:0] A_SEL_B   = 2'd1;
    localparam logic [1:0] A_SEL_SUB = 2'd2;
    localparam logic       B_SEL_IN  = 1'b0;
    localparam logic       B_SEL_A   = 1'b1;

endpackage

// File: rtl/gcd_perf_counter.sv
// gcd_perf_counter: saturating up-counter with synchronous clear and increment
// Ports: clk, reset (async active-high), clr_i (clear to 0), inc_i (count up one), cnt_o (count, sticks at all-ones)
module gcd_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gcd_unit_ctrl.sv
// gcd_unit_ctrl: IDLE/CALC/DONE controller sequencing Euclid-by-subtraction on the GCD datapath
// Ports: clk, reset (async active-high); in_val/in_rdy request handshake; out_val/out_rdy response handshake;
//        sel_A/sel_B/en_A/en_B datapath mux selects and register enables; is_A_lt_B/is_B_neq_0 datapath status;
//        busy_cycles CALC-cycle count of the last/current transaction.
// Config: define GCD_CTRL_PERF_EN to build the busy-cycle counter; otherwise busy_cycles is tied to 0.
module gcd_unit_ctrl
    import gcd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [1:0]       sel_A,
    output logic             sel_B,
    output logic             en_A,
    output logic             en_B,
    input  logic             is_A_lt_B,
    input  logic             is_B_neq_0,
    output logic [CNT_W-1:0] busy_cycles
);

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Outputs are gated by reset so the handshake and enables go quiet
    // the moment reset rises, not at the next edge.
    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_val = 1'b0;
        en_A    = 1'b0;
        en_B    = 1'b0;
        sel_A   = A_SEL_IN;
        sel_B   = B_SEL_IN;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    in_rdy = 1'b1;
                    if (in_val) begin
                        en_A    = 1'b1;
                        en_B    = 1'b1;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    if (is_A_lt_B) begin
                        en_A  = 1'b1;
                        en_B  = 1'b1;
                        sel_A = A_SEL_B;
                        sel_B = B_SEL_A;
                    end else if (is_B_neq_0) begin
                        en_A  = 1'b1;
                        sel_A = A_SEL_SUB;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    out_val = 1'b1;
                    state_d = out_rdy ? IDLE : DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef GCD_CTRL_PERF_EN
    gcd_perf_counter #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk  (clk),
        .reset(reset),
        .clr_i(in_val && in_rdy),
        .inc_i(state_q == CALC),
        .cnt_o(busy_cycles)
    );
`else
    assign busy_cycles = '0;
`endif

endmodule
